register_file: RTL and testbench

Parametrised multi-entry register file for the 16-bit CPU datapath. It generalises the single load-enabled register into DEPTH entries, with two combinational read ports, one synchronous write port, optional write-to-read bypass, optional hardwired-zero entry 0, and a per-entry pending-write scoreboard. It sits between decode (read addresses, busy marking) and writeback (write port).

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_entry.sv | 57 +++++
 rtl/register_file.sv | 92 +++++++++
 tb/tb_register_file.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants and the register-file entry state type.
// Imported by the register file and its per-entry storage.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_DEPTH  = 8;
    localparam int REG_ADDR_W = $clog2(REG_DEPTH);
    localparam int ZERO_ADDR  = 0;

    // Scoreboard state of one entry: waiting for its writeback or not.
    typedef enum logic {
        ENTRY_IDLE    = 1'b0,
        ENTRY_PENDING = 1'b1
    } entry_state_t;

endpackage

// File: rtl/regfile_entry.sv
// One register-file entry: a load-enabled data register plus its
// pending-write flag, both cleared asynchronously by rst.
module regfile_entry
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             set_busy,
    input  logic             clr_busy,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    entry_state_t state_q;
    entry_state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTRY_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new producer marking the entry outranks the retiring writeback.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTRY_IDLE: begin
                if (set_busy) begin
                    state_d = ENTRY_PENDING;
                end
            end
            ENTRY_PENDING: begin
                if (clr_busy && !set_busy) begin
                    state_d = ENTRY_IDLE;
                end
            end
            default: state_d = ENTRY_IDLE;
        endcase
    end

    assign busy = (state_q == ENTRY_PENDING);

endmodule

// File: rtl/register_file.sv
// DEPTH-entry register file: two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero entry 0, busy scoreboard.
module register_file
    import cpu_pkg::*;
#(
    parameter  int WIDTH    = DATA_W,
    parameter  int DEPTH    = REG_DEPTH,
    parameter  bit ZERO_REG = 1'b1,
    parameter  bit BYPASS   = 1'b1,
    localparam int ADDR_W   = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              busy_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              busy_b,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr
);

    logic [WIDTH-1:0]  entry_q [DEPTH];
    logic [DEPTH-1:0]  entry_busy;
    logic [ADDR_W-1:0] raddr   [2];
    logic [WIDTH-1:0]  rdata   [2];
    logic [1:0]        rbusy;

    // Addresses at or beyond DEPTH match no entry, so they are dropped here.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam bit IS_ZERO = ZERO_REG && (i == ZERO_ADDR);
        logic whit;
        logic bhit;

        assign whit = (waddr == ADDR_W'(i)) && !IS_ZERO;
        assign bhit = (busy_addr == ADDR_W'(i)) && !IS_ZERO;

        regfile_entry #(
            .WIDTH(WIDTH)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (wen && whit),
            .din      (wdata),
            .set_busy (busy_set && bhit),
            .clr_busy (wen && whit),
            .q        (entry_q[i]),
            .busy     (entry_busy[i])
        );
    end

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;

    // Each read port: select stored entry, then apply zero-reg, bypass and reset gating.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [WIDTH-1:0] stored;
        logic             stored_busy;
        logic             valid;
        logic             fwd;
        logic             reset_pending;

        always_comb begin
            stored      = '0;
            stored_busy = 1'b0;
            valid       = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (raddr[p] == ADDR_W'(i)) begin
                    stored      = entry_q[i];
                    stored_busy = entry_busy[i];
                    valid       = !(ZERO_REG && (i == ZERO_ADDR));
                end
            end
        end

        assign fwd           = BYPASS && wen && (waddr == raddr[p]) && valid;
        assign reset_pending = busy_set && (busy_addr == raddr[p]);

        assign rdata[p] = (rst || !valid) ? '0 : (fwd ? wdata : stored);
        assign rbusy[p] = !rst && valid && stored_busy && !(fwd && !reset_pending);
    end

    assign rdata_a = rdata[0];
    assign rdata_b = rdata[1];
    assign busy_a  = rbusy[0];
    assign busy_b  = rbusy[1];

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: a default instance and a DEPTH=6, no-bypass,
// no-zero-reg instance share stimulus and are checked against an array model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  raddr_a, raddr_b, waddr, busy_addr;
    logic        wen, busy_set;
    logic [15:0] wdata;

    logic [15:0] rdata_a1, rdata_b1, rdata_a2, rdata_b2;
    logic        busy_a1, busy_b1, busy_a2, busy_b2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] mmem  [2][8];
    logic        mbusy [2][8];
    int          mdepth [2] = '{8, 6};
    bit          mzero  [2] = '{1'b1, 1'b0};
    bit          mbyp   [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    register_file dut1 (
        .clk(clk), .rst(rst),
        .raddr_a(raddr_a), .rdata_a(rdata_a1), .busy_a(busy_a1),
        .raddr_b(raddr_b), .rdata_b(rdata_b1), .busy_b(busy_b1),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    register_file #(.DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut2 (
        .clk(clk), .rst(rst),
        .raddr_a(raddr_a), .rdata_a(rdata_a2), .busy_a(busy_a2),
        .raddr_b(raddr_b), .rdata_b(rdata_b2), .busy_b(busy_b2),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    function automatic logic [15:0] exp_rdata(int m, int addr);
        if (rst || addr >= mdepth[m] || (mzero[m] && addr == 0)) return 16'h0;
        if (mbyp[m] && wen && int'(waddr) == addr) return wdata;
        return mmem[m][addr];
    endfunction

    function automatic logic exp_busy(int m, int addr);
        if (rst || addr >= mdepth[m] || (mzero[m] && addr == 0)) return 1'b0;
        if (mbyp[m] && wen && int'(waddr) == addr && !(busy_set && int'(busy_addr) == addr))
            return 1'b0;
        return mbusy[m][addr];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 8; i++) begin
                mmem[m][i]  = 16'h0;
                mbusy[m][i] = 1'b0;
            end
    endtask

    // Apply the edge to the model: write retires first, then a new mark wins.
    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (wen && int'(waddr) < mdepth[m] && !(mzero[m] && waddr == 3'd0)) begin
                    mmem[m][waddr]  = wdata;
                    mbusy[m][waddr] = 1'b0;
                end
                if (busy_set && int'(busy_addr) < mdepth[m] && !(mzero[m] && busy_addr == 3'd0))
                    mbusy[m][busy_addr] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests_run++; if (rdata_a1 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_init rdata_a1: got %h want 0000", rdata_a1); end
        tests_run++; if (busy_a1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_init busy_a1: got %b want 0", busy_a1); end
        tests_run++; if (rdata_b2 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_init rdata_b2: got %h want 0000", rdata_b2); end
        tick(); tick();
        rst = 1'b0;
        wen = 1'b1; waddr = 3'd3; wdata = 16'h1234;
        tick();
        wen = 1'b0; raddr_a = 3'd3;
        #1;
        tests_run++; if (rdata_a1 !== 16'h1234) begin tests_failed++; $display("[TB] FAIL reset_prewrite rdata_a1: got %h want 1234", rdata_a1); end
        tests_run++; if (rdata_a2 !== 16'h1234) begin tests_failed++; $display("[TB] FAIL reset_prewrite rdata_a2: got %h want 1234", rdata_a2); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (rdata_a1 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_async rdata_a1: got %h want 0000", rdata_a1); end
        tests_run++; if (busy_a1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_async busy_a1: got %b want 0", busy_a1); end
        tests_run++; if (rdata_a2 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_async rdata_a2: got %h want 0000", rdata_a2); end
        wen = 1'b1; waddr = 3'd3; wdata = 16'h5555;
        tick();
        rst = 1'b0; wen = 1'b0;
        #1;
        tests_run++; if (rdata_a1 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_discard rdata_a1: got %h want 0000", rdata_a1); end
        tests_run++; if (rdata_a2 !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_discard rdata_a2: got %h want 0000", rdata_a2); end
    endtask

    task automatic test_write_hold();
        wen = 1'b1; waddr = 3'd2; wdata = 16'hAAAA; raddr_b = 3'd2;
        tick();
        wen = 1'b0; wdata = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++; if (rdata_b1 !== 16'hAAAA) begin tests_failed++; $display("[TB] FAIL hold%0d rdata_b1: got %h want aaaa", c, rdata_b1); end
            tests_run++; if (rdata_b2 !== 16'hAAAA) begin tests_failed++; $display("[TB] FAIL hold%0d rdata_b2: got %h want aaaa", c, rdata_b2); end
            tick();
        end
    endtask

    task automatic test_bypass();
        wen = 1'b1; waddr = 3'd5; wdata = 16'h0001;
        tick();
        wdata = 16'h1234; raddr_a = 3'd5;
        #1;
        tests_run++; if (rdata_a1 !== 16'h1234) begin tests_failed++; $display("[TB] FAIL bypass_on rdata_a1: got %h want 1234", rdata_a1); end
        tests_run++; if (rdata_a2 !== 16'h0001) begin tests_failed++; $display("[TB] FAIL bypass_off rdata_a2: got %h want 0001", rdata_a2); end
        tick();
        wen = 1'b0;
        #1;
        tests_run++; if (rdata_a1 !== 16'h1234) begin tests_failed++; $display("[TB] FAIL bypass_after rdata_a1: got %h want 1234", rdata_a1); end
        tests_run++; if (rdata_a2 !== 16'h1234) begin tests_failed++; $display("[TB] FAIL bypass_after rdata_a2: got %h want 1234", rdata_a2); end
    endtask

    task automatic test_zero_reg();
        wen = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
        busy_set = 1'b1; busy_addr = 3'd0; raddr_a = 3'd0;
        #1;
        tests_run++; if (rdata_a1 !== 16'h0) begin tests_failed++; $display("[TB] FAIL zero_nobypass rdata_a1: got %h want 0000", rdata_a1); end
        tick();
        wen = 1'b0; busy_set = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++; if (rdata_a1 !== 16'h0) begin tests_failed++; $display("[TB] FAIL zero%0d rdata_a1: got %h want 0000", c, rdata_a1); end
            tests_run++; if (busy_a1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero%0d busy_a1: got %b want 0", c, busy_a1); end
            tests_run++; if (rdata_a2 !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL nozero%0d rdata_a2: got %h want ffff", c, rdata_a2); end
            tests_run++; if (busy_a2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL nozero%0d busy_a2: got %b want 1", c, busy_a2); end
            tick();
        end
        wen = 1'b1; waddr = 3'd0; wdata = 16'h0;
        tick();
        wen = 1'b0;
    endtask

    task automatic test_scoreboard();
        raddr_b = 3'd4; busy_set = 1'b1; busy_addr = 3'd4;
        tick();
        busy_set = 1'b0;
        #1;
        tests_run++; if (busy_b1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_set busy_b1: got %b want 1", busy_b1); end
        tests_run++; if (busy_b2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_set busy_b2: got %b want 1", busy_b2); end
        wen = 1'b1; waddr = 3'd4; wdata = 16'h00FF;
        #1;
        tests_run++; if (busy_b1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_wrcycle busy_b1: got %b want 0", busy_b1); end
        tests_run++; if (busy_b2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_wrcycle busy_b2: got %b want 1", busy_b2); end
        tests_run++; if (rdata_b1 !== 16'h00FF) begin tests_failed++; $display("[TB] FAIL sb_wrcycle rdata_b1: got %h want 00ff", rdata_b1); end
        tick();
        wen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++; if (busy_b1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_clear%0d busy_b1: got %b want 0", c, busy_b1); end
            tests_run++; if (busy_b2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_clear%0d busy_b2: got %b want 0", c, busy_b2); end
            tick();
        end
        busy_set = 1'b1; busy_addr = 3'd4; wen = 1'b1; waddr = 3'd4; wdata = 16'h00FF;
        tick();
        busy_set = 1'b0; wen = 1'b0;
        #1;
        tests_run++; if (busy_b1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_setwins busy_b1: got %b want 1", busy_b1); end
        tests_run++; if (busy_b2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_setwins busy_b2: got %b want 1", busy_b2); end
        tests_run++; if (rdata_b1 !== 16'h00FF) begin tests_failed++; $display("[TB] FAIL sb_setwins rdata_b1: got %h want 00ff", rdata_b1); end
        wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic test_invalid();
        wen = 1'b1; waddr = 3'd7; wdata = 16'hBEEF;
        busy_set = 1'b1; busy_addr = 3'd7; raddr_a = 3'd7;
        tick();
        wen = 1'b0; busy_set = 1'b0;
        #1;
        tests_run++; if (rdata_a2 !== 16'h0) begin tests_failed++; $display("[TB] FAIL invalid rdata_a2: got %h want 0000", rdata_a2); end
        tests_run++; if (busy_a2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL invalid busy_a2: got %b want 0", busy_a2); end
        tests_run++; if (rdata_a1 !== 16'hBEEF) begin tests_failed++; $display("[TB] FAIL valid7 rdata_a1: got %h want beef", rdata_a1); end
        tests_run++; if (busy_a1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL valid7 busy_a1: got %b want 1", busy_a1); end
        for (int i = 0; i < 6; i++) begin
            raddr_b = 3'(i);
            #1;
            tests_run++; if (rdata_b2 !== mmem[1][i]) begin tests_failed++; $display("[TB] FAIL invalid_keep r%0d rdata_b2: got %h want %h", i, rdata_b2, mmem[1][i]); end
        end
        wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            wen       = $urandom_range(0, 1) == 1;
            waddr     = 3'($urandom_range(0, 7));
            wdata     = 16'($urandom);
            busy_set  = $urandom_range(0, 2) == 0;
            busy_addr = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            raddr_a   = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
            raddr_b   = ($urandom_range(0, 2) == 0) ? busy_addr : 3'($urandom_range(0, 7));
            #1;
            for (int m = 0; m < 2; m++) begin
                logic [15:0] ga, gb;
                logic        gba, gbb;
                ga  = (m == 0) ? rdata_a1 : rdata_a2;
                gb  = (m == 0) ? rdata_b1 : rdata_b2;
                gba = (m == 0) ? busy_a1 : busy_a2;
                gbb = (m == 0) ? busy_b1 : busy_b2;
                tests_run++; if (ga !== exp_rdata(m, int'(raddr_a))) begin tests_failed++; $display("[TB] FAIL rand%0d dut%0d rdata_a: got %h want %h", c, m + 1, ga, exp_rdata(m, int'(raddr_a))); end
                tests_run++; if (gb !== exp_rdata(m, int'(raddr_b))) begin tests_failed++; $display("[TB] FAIL rand%0d dut%0d rdata_b: got %h want %h", c, m + 1, gb, exp_rdata(m, int'(raddr_b))); end
                tests_run++; if (gba !== exp_busy(m, int'(raddr_a))) begin tests_failed++; $display("[TB] FAIL rand%0d dut%0d busy_a: got %b want %b", c, m + 1, gba, exp_busy(m, int'(raddr_a))); end
                tests_run++; if (gbb !== exp_busy(m, int'(raddr_b))) begin tests_failed++; $display("[TB] FAIL rand%0d dut%0d busy_b: got %b want %b", c, m + 1, gbb, exp_busy(m, int'(raddr_b))); end
            end
            tick();
        end
        rst = 1'b0; wen = 1'b0; busy_set = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; busy_set = 1'b0;
        raddr_a = 3'd0; raddr_b = 3'd0; waddr = 3'd0; busy_addr = 3'd0; wdata = 16'h0;
        model_reset();
        test_reset();
        test_write_hold();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_invalid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
